alu_issue_stage: RTL and testbench



---
 rtl/alu_issue_if.sv | 32 +++
 rtl/alu_issue_stage.sv | 201 ++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Upstream request and downstream writeback handshakes of the ALU issue stage.
// master = producer of requests / consumer of results; slave = the stage itself.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_aluop;
  logic [5:0]  in_funct;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_overflow;
  logic        out_illegal;
  logic        out_trap;
  logic [4:0]  out_tag;

  modport master (
    output in_valid, in_aluop, in_funct, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_overflow,
           out_illegal, out_trap, out_tag
  );

  modport slave (
    input  in_valid, in_aluop, in_funct, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_overflow,
           out_illegal, out_trap, out_tag
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue/capture stage around a combinational 32-bit ALU: decode, execute, hold result.
// Optional build macro ALU_ISSUE_TRAP_EN enables the signed add/sub overflow trap.
module alu_issue_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_if.slave       bus,
  output logic [31:0]      alu_a_in,
  output logic [31:0]      alu_b_in,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  state_e r_state;
  state_e w_state_nxt;

  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_accept;
  logic       w_capture;

  logic [3:0] w_dec_op;
  logic       w_dec_illegal;

  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [3:0]  r_alu_op;
  logic [4:0]  r_tag;
  logic        r_illegal;

  logic        w_ovf_masked;
  logic        w_trap;
  logic [4:0]  w_tag_cap;

  logic [31:0]      r_out_result;
  logic             r_out_zero;
  logic             r_out_overflow;
  logic             r_out_illegal;
  logic             r_out_trap;
  logic [4:0]       r_out_tag;
  logic [CNT_W-1:0] r_ovf_count;

  // NOTE: every signal written in an always_comb gets a default first, so no path
  // through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    w_dec_op      = OP_AND;
    w_dec_illegal = 1'b0;
    case (bus.in_aluop)
      2'b00: w_dec_op = OP_ADD;
      2'b01: w_dec_op = OP_SUB;
      2'b10: begin
        case (bus.in_funct)
          6'b100000, 6'b100001: w_dec_op = OP_ADD;
          6'b100010, 6'b100011: w_dec_op = OP_SUB;
          6'b100100:            w_dec_op = OP_AND;
          6'b100101:            w_dec_op = OP_OR;
          6'b100111:            w_dec_op = OP_NOR;
          6'b101010:            w_dec_op = OP_SLT;
          default:              w_dec_illegal = 1'b1;
        endcase
      end
      default: w_dec_illegal = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid)  w_state_nxt = ST_EXEC;
      ST_EXEC:                    w_state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready  = 1'b1;
      ST_EXEC: w_capture   = 1'b1;
      ST_DONE: w_out_valid = 1'b1;
      default: ;
    endcase
    w_accept = w_in_ready & bus.in_valid;
  end

  // Operands and opcode only change on acceptance, so the ALU sees them stable in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= OP_AND;
      r_tag     <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_alu_a   <= bus.in_a;
      r_alu_b   <= bus.in_b;
      r_alu_op  <= w_dec_op;
      r_tag     <= bus.in_tag;
      r_illegal <= w_dec_illegal;
    end
  end

  // The ALU flags overflow for any op; only add/sub overflow is architecturally meaningful.
  assign w_ovf_masked = alu_overflow & ~r_illegal &
                        ((r_alu_op == OP_ADD) | (r_alu_op == OP_SUB));

`ifdef ALU_ISSUE_TRAP_EN
  logic w_dec_signed;
  logic r_signed;

  // Only add/sub (not addu/subu, not ALUOp 00/01) can trap.
  assign w_dec_signed = (bus.in_aluop == 2'b10) &
                        ((bus.in_funct == 6'b100000) | (bus.in_funct == 6'b100010));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_signed <= 1'b0;
    end else if (w_accept) begin
      r_signed <= w_dec_signed;
    end
  end

  // A trapping op writes register 0, which squashes the architectural write.
  assign w_trap    = w_ovf_masked & r_signed;
  assign w_tag_cap = w_trap ? 5'd0 : r_tag;
`else
  assign w_trap    = 1'b0;
  assign w_tag_cap = r_tag;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_result   <= '0;
      r_out_zero     <= 1'b0;
      r_out_overflow <= 1'b0;
      r_out_illegal  <= 1'b0;
      r_out_trap     <= 1'b0;
      r_out_tag      <= '0;
    end else if (w_capture) begin
      r_out_result   <= alu_result;
      r_out_zero     <= alu_zero;
      r_out_overflow <= w_ovf_masked;
      r_out_illegal  <= r_illegal;
      r_out_trap     <= w_trap;
      r_out_tag      <= w_tag_cap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_count <= '0;
    end else if (w_capture && w_ovf_masked && (r_ovf_count != '1)) begin
      r_ovf_count <= r_ovf_count + CNT_W'(1);
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_result   = r_out_result;
  assign bus.out_zero     = r_out_zero;
  assign bus.out_overflow = r_out_overflow;
  assign bus.out_illegal  = r_out_illegal;
  assign bus.out_trap     = r_out_trap;
  assign bus.out_tag      = r_out_tag;

  assign alu_a_in  = r_alu_a;
  assign alu_b_in  = r_alu_b;
  assign alu_op    = r_alu_op;
  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized scoreboard bench for alu_issue_stage; the bench also plays the combinational ALU.
// Build with ALU_ISSUE_TRAP_EN defined to check the trap variant.
module tb_alu_issue_stage;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if bus ();

  logic [31:0]      alu_a_in, alu_b_in, alu_result;
  logic [3:0]       alu_op;
  logic             alu_zero, alu_overflow;
  logic [CNT_W-1:0] ovf_count;

  alu_issue_stage #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_a_in     (alu_a_in),
    .alu_b_in     (alu_b_in),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .ovf_count    (ovf_count)
  );

  // Stand-in for the ripple-carry ALU; overflow is deliberately raised for non add/sub
  // ops too (using the adder's view) so the stage's masking is exercised.
  logic [31:0] w_sum, w_diff;
  logic        w_add_ovf, w_sub_ovf;
  always_comb begin
    w_sum     = alu_a_in + alu_b_in;
    w_diff    = alu_a_in - alu_b_in;
    w_add_ovf = (alu_a_in[31] == alu_b_in[31]) && (w_sum[31] != alu_a_in[31]);
    w_sub_ovf = (alu_a_in[31] != alu_b_in[31]) && (w_diff[31] != alu_a_in[31]);
    case (alu_op)
      4'b0000: alu_result = alu_a_in & alu_b_in;
      4'b0001: alu_result = alu_a_in | alu_b_in;
      4'b0010: alu_result = w_sum;
      4'b0110: alu_result = w_diff;
      4'b0111: alu_result = {31'd0, $signed(alu_a_in) < $signed(alu_b_in)};
      4'b1100: alu_result = ~(alu_a_in | alu_b_in);
      default: alu_result = 32'd0;
    endcase
    alu_zero     = (alu_result == 32'd0);
    alu_overflow = (alu_op == 4'b0110 || alu_op == 4'b0111) ? w_sub_ovf : w_add_ovf;
  end

  typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_NOR, K_SLT, K_ILL} kind_e;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        illegal;
    logic        trap;
    logic [4:0]  tag;
    logic [31:0] count;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   model_count = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of a request, computed with plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] aluop, input logic [5:0] funct,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag);
    exp_t   e;
    kind_e  k;
    longint sa, sb, wide;
    bit     signed_op;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (aluop == 2'd0)      k = K_ADD;
    else if (aluop == 2'd1) k = K_SUB;
    else if (aluop == 2'd3) k = K_ILL;
    else begin
      case (funct)
        6'h20, 6'h21: k = K_ADD;
        6'h22, 6'h23: k = K_SUB;
        6'h24:        k = K_AND;
        6'h25:        k = K_OR;
        6'h27:        k = K_NOR;
        6'h2A:        k = K_SLT;
        default:      k = K_ILL;
      endcase
    end
    e.ovf = 1'b0;
    case (k)
      K_ADD: begin e.op = 4'b0010; wide = sa + sb; e.result = a + b; e.ovf = (wide != longint'(int'(wide))); end
      K_SUB: begin e.op = 4'b0110; wide = sa - sb; e.result = a - b; e.ovf = (wide != longint'(int'(wide))); end
      K_AND: begin e.op = 4'b0000; e.result = a & b; end
      K_OR:  begin e.op = 4'b0001; e.result = a | b; end
      K_NOR: begin e.op = 4'b1100; e.result = ~(a | b); end
      K_SLT: begin e.op = 4'b0111; e.result = (sa < sb) ? 32'd1 : 32'd0; end
      default: begin e.op = 4'b0000; e.result = a & b; end
    endcase
    e.illegal = (k == K_ILL);
    e.zero    = (e.result == 32'd0);
    signed_op = (aluop == 2'd2) && (funct == 6'h20 || funct == 6'h22);
`ifdef ALU_ISSUE_TRAP_EN
    e.trap = e.ovf && signed_op;
`else
    e.trap = 1'b0;
    if (signed_op) e.trap = 1'b0;
`endif
    e.tag   = e.trap ? 5'd0 : tag;
    e.count = 32'd0;
    return e;
  endfunction

  // Scoreboard monitor: every cycle with a presented result is compared to the head entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
      end else begin
        e = q[0];
        check("out_result",   bus.out_result,         e.result);
        check("out_zero",     32'(bus.out_zero),      32'(e.zero));
        check("out_overflow", 32'(bus.out_overflow),  32'(e.ovf));
        check("out_illegal",  32'(bus.out_illegal),   32'(e.illegal));
        check("out_trap",     32'(bus.out_trap),      32'(e.trap));
        check("out_tag",      32'(bus.out_tag),       32'(e.tag));
        check("ovf_count",    32'(ovf_count),         e.count);
        check("in_ready_busy", 32'(bus.in_ready),     32'd0);
        if (bus.out_ready) void'(q.pop_front());
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at a negedge; returns at the negedge in DONE, or in EXEC when abort is set.
  task automatic send(input logic [1:0] aluop, input logic [5:0] funct,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input bit abort);
    exp_t e;
    int   waited = 0;
    bus.in_valid = 1'b1;
    bus.in_aluop = aluop;
    bus.in_funct = funct;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    while (!bus.in_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    e = model(aluop, funct, a, b, tag);
    if (e.ovf && model_count < CNT_MAX) model_count++;
    e.count = 32'(model_count);
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("exec_op",       32'(alu_op),        32'(e.op));
    check("exec_a",        alu_a_in,           a);
    check("exec_b",        alu_b_in,           b);
    check("exec_no_valid", 32'(bus.out_valid), 32'd0);
    if (abort) return;
    @(negedge clk);
    check("done_valid",    32'(bus.out_valid), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!(q.size() == 0 && !bus.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag_name);
    check({tag_name, "_out_valid"},  32'(bus.out_valid),    32'd0);
    check({tag_name, "_out_result"}, bus.out_result,        32'd0);
    check({tag_name, "_out_flags"},  32'({bus.out_zero, bus.out_overflow, bus.out_illegal, bus.out_trap}), 32'd0);
    check({tag_name, "_out_tag"},    32'(bus.out_tag),      32'd0);
    check({tag_name, "_ovf_count"},  32'(ovf_count),        32'd0);
    check({tag_name, "_alu_a"},      alu_a_in,              32'd0);
    check({tag_name, "_alu_b"},      alu_b_in,              32'd0);
    check({tag_name, "_alu_op"},     32'(alu_op),           32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd0;
      4: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] legal_funct [8];
    legal_funct = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
    bus.in_valid  = 1'b0;
    bus.in_aluop  = 2'd0;
    bus.in_funct  = 6'd0;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.in_tag    = 5'd0;
    bus.out_ready = 1'b0;

    #2;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rand_ready = 1'b1;

    send(2'b10, 6'h20, 32'd2000, 32'd1000, 5'd5, 1'b0);
    send(2'b10, 6'h22, 32'd1000, 32'd1000, 5'd6, 1'b0);
    send(2'b10, 6'h2A, 32'd1000, 32'd2000, 5'd7, 1'b0);
    send(2'b10, 6'h2A, 32'd2000, 32'd1000, 5'd8, 1'b0);
    send(2'b10, 6'h20, 32'h7FFF_FFFF, 32'd1, 5'd9, 1'b0);
    send(2'b10, 6'h21, 32'h7FFF_FFFF, 32'd1, 5'd10, 1'b0);
    send(2'b10, 6'h3F, 32'h7FFF_FFFF, 32'd1, 5'd11, 1'b0);
    send(2'b11, 6'h20, 32'h1234_5678, 32'h0F0F_0F0F, 5'd12, 1'b0);
    send(2'b10, 6'h27, 32'd0, 32'd0, 5'd13, 1'b0);
    send(2'b10, 6'h24, 32'h7FFF_FFFF, 32'd1, 5'd14, 1'b0);
    send(2'b01, 6'h00, 32'h8000_0000, 32'd1, 5'd15, 1'b0);

    // Backpressure: hold the result while upstream keeps changing its request.
    wait_drain();
    rand_ready    = 1'b0;
    bus.out_ready = 1'b0;
    send(2'b10, 6'h25, 32'hA5A5_0000, 32'h0000_5A5A, 5'd17, 1'b0);
    repeat (10) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_a     = $urandom;
      bus.in_b     = $urandom;
      bus.in_tag   = 5'($urandom);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rand_ready    = 1'b1;

    // Reset while an op is executing, with a non-zero overflow count.
    wait_drain();
    check("pre_reset_count", 32'(ovf_count), 32'(model_count));
    send(2'b10, 6'h20, 32'h7FFF_FFFF, 32'd5, 5'd20, 1'b1);
    rst_n = 1'b0;
    q.delete();
    model_count = 0;
    #1;
    check_all_zero("midexec_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(negedge clk);

    // Drive the narrow counter into saturation.
    repeat (CNT_MAX + 2) send(2'b00, 6'($urandom), 32'h7FFF_FFFF, 32'd1, 5'($urandom), 1'b0);

    for (int i = 0; i < 150; i++) begin
      logic [1:0] aluop;
      logic [5:0] funct;
      aluop = 2'($urandom_range(0, 3));
      funct = ($urandom_range(0, 4) != 0) ? legal_funct[$urandom_range(0, 7)] : 6'($urandom);
      send(aluop, funct, pick_operand(), pick_operand(), 5'($urandom), 1'b0);
    end

    wait_drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
